// File: rtl/fetch_stage.sv
// Instruction fetch stage: fetch PC, synchronous I-SRAM request, and a one-entry skid buffer
// that holds the fetched word while decode stalls. Redirects on a taken branch cancel from decode.
module fetch_stage #(
    parameter int                    PC_WIDTH    = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC    = 32'h8000_0000,
    localparam int IF_TO_ID_BUS_WIDTH = PC_WIDTH + INSTR_WIDTH,
    localparam int ID_TO_IF_BUS_WIDTH = PC_WIDTH + 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          id_allow_in,
    output logic                          if_to_id_valid,
    output logic [IF_TO_ID_BUS_WIDTH-1:0] if_to_id_bus,
    input  logic [ID_TO_IF_BUS_WIDTH-1:0] id_to_if_bus,
    output logic                          inst_sram_en,
    output logic [PC_WIDTH-1:0]           inst_sram_addr,
    input  logic [INSTR_WIDTH-1:0]        inst_sram_rdata
);

    localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

    logic                   branch_taken;
    logic [PC_WIDTH-1:0]    branch_target;
    logic                   branch_taken_cancel;
    logic [PC_WIDTH-1:0]    redirect_pc;

    logic                   if_valid;
    logic [PC_WIDTH-1:0]    if_pc;
    logic [PC_WIDTH-1:0]    pf_pc;
    logic                   buf_valid;
    logic [INSTR_WIDTH-1:0] buf_inst;
    logic [INSTR_WIDTH-1:0] if_inst;

    logic                   if_ready_go;
    logic                   if_allow_in;
    logic                   issue;
    logic                   unused_bits;

    assign {branch_taken, branch_target, branch_taken_cancel} = id_to_if_bus;
    // branch_taken alone means decode has not fired; only the cancel bit redirects.
    assign unused_bits = ^{branch_taken, branch_target[1:0], if_ready_go};
    assign redirect_pc = {branch_target[PC_WIDTH-1:2], 2'b00};

    assign if_ready_go    = if_valid;
    assign if_allow_in    = !if_valid || id_allow_in;
    assign issue          = !rst && (if_allow_in || branch_taken_cancel);

    assign inst_sram_en   = issue;
    assign inst_sram_addr = branch_taken_cancel ? redirect_pc : pf_pc;

    assign if_inst        = buf_valid ? buf_inst : inst_sram_rdata;
    assign if_to_id_valid = if_valid && !branch_taken_cancel;
    assign if_to_id_bus   = {if_pc, if_inst};

    always_ff @(posedge clk) begin
        if (rst) begin
            if_valid  <= 1'b0;
            if_pc     <= RESET_PC;
            pf_pc     <= RESET_PC;
            buf_valid <= 1'b0;
            buf_inst  <= '0;
        end else if (issue) begin
            if_valid  <= 1'b1;
            if_pc     <= inst_sram_addr;
            pf_pc     <= inst_sram_addr + PC_STEP;
            buf_valid <= 1'b0;
        end else if (!buf_valid) begin
            // Not issuing implies IF is valid and stalled: capture rdata while it is still defined.
            buf_valid <= 1'b1;
            buf_inst  <= inst_sram_rdata;
        end
    end

endmodule
